// File: rtl/ex_md_unit_pkg.sv
// ex_md_unit_pkg: shared widths, instruction ids and divider state encodings
// for the execution unit and its iterative divider.
package ex_md_unit_pkg;

    localparam int unsigned INSTR_ID_W = 6;
    localparam int unsigned ROB_IDX_W  = 4;

    // Decoded instruction ids; the RV32M ids follow the base ids.
    typedef enum logic [INSTR_ID_W-1:0] {
        ID_NOP    = 6'd0,
        ID_LUI, ID_AUIPC, ID_JAL, ID_JALR,
        ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU,
        ID_ADDI, ID_SLTI, ID_SLTIU, ID_XORI, ID_ORI, ID_ANDI,
        ID_SLLI, ID_SRLI, ID_SRAI,
        ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU, ID_XOR,
        ID_SRL, ID_SRA, ID_OR, ID_AND,
        ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU,
        ID_DIV, ID_DIVU, ID_REM, ID_REMU
    } instr_id_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input instr_id_e op);
        return op inside {ID_DIV, ID_DIVU, ID_REM, ID_REMU};
    endfunction

endpackage

// File: rtl/ex_md_unit_div_iter.sv
// ex_md_unit_div_iter: restoring radix-2 divider, one quotient bit per cycle.
// Ports: clk_in/rst_in (sync, active-high)/rdy_in (freeze)/clear_in (flush);
//        start_i with signed_i, rem_i, a_i (dividend), b_i (divisor);
//        idle_c (FSM idle), done_c (result valid this cycle), result_c.
module ex_md_unit_div_iter
    import ex_md_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear_in,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic            rem_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            idle_c,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;    // dividend shifts out, quotient shifts in
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              sel_rem_q, sel_rem_d;
    logic              dz_q, dz_d;

    logic              a_neg, b_neg;
    logic [XLEN:0]     r_shift, diff;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Next-state and datapath for one restoring step per RUN cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;
        dz_d      = dz_q;

        a_neg   = signed_i & a_i[XLEN-1];
        b_neg   = signed_i & b_i[XLEN-1];
        r_shift = {rem_q, quo_q[XLEN-1]};
        diff    = r_shift - {1'b0, dvs_q};

        unique case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    state_d   = DIV_RUN;
                    cnt_d     = CNT_W'(XLEN - 1);
                    quo_d     = a_neg ? (~a_i + XLEN'(1)) : a_i;
                    rem_d     = '0;
                    dvs_d     = b_neg ? (~b_i + XLEN'(1)) : b_i;
                    q_neg_d   = a_neg ^ b_neg;
                    r_neg_d   = a_neg;
                    sel_rem_d = rem_i;
                    dz_d      = (b_i == '0);
                end
            end
            DIV_RUN: begin
                // Borrow out of diff means the trial subtraction failed.
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = r_shift[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (clear_in) begin
            state_d = DIV_IDLE;
        end
    end

    // State register; rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            sel_rem_q <= sel_rem_d;
            dz_q      <= dz_d;
        end
    end

    // Sign fix-up. Divide by zero forces an all-ones quotient; the remainder
    // already equals rs1. The -2^(XLEN-1)/-1 overflow falls out naturally.
    always_comb begin
        quo_fix = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
        rem_fix = r_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
        if (dz_q) begin
            quo_fix = '1;
        end
    end

    assign idle_c   = (state_q == DIV_IDLE);
    assign done_c   = (state_q == DIV_DONE);
    assign result_c = sel_rem_q ? rem_fix : quo_fix;

endmodule

// File: rtl/ex_md_unit.sv
// ex_md_unit: registered execution unit (base ALU, branches, jumps, RV32M).
// Ports: clk_in, rst_in (sync, active-high), rdy_in (freeze), clear_in (flush);
//        issue_valid_in/issue_ready_out handshake with instr_id_in, imm_in,
//        rs1_in, rs2_in, pc_in, rob_pos_in; results on res_valid_out, res_out,
//        jump_en_out, jump_a_out, rob_pos_out; busy_out when anything in flight.
// MUL_STAGES must be 1..8 and below XLEN so the pipeline drains during a divide.
module ex_md_unit
    import ex_md_unit_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned SHAMT_W    = $clog2(XLEN)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  issue_valid_in,
    output logic                  issue_ready_out,
    input  logic [INSTR_ID_W-1:0] instr_id_in,
    input  logic [XLEN-1:0]       imm_in,
    input  logic [XLEN-1:0]       rs1_in,
    input  logic [XLEN-1:0]       rs2_in,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [ROB_IDX_W-1:0]  rob_pos_in,
    output logic                  res_valid_out,
    output logic [XLEN-1:0]       res_out,
    output logic                  jump_en_out,
    output logic [XLEN-1:0]       jump_a_out,
    output logic [ROB_IDX_W-1:0]  rob_pos_out,
    output logic                  busy_out
);

    instr_id_e            op;
    logic                 accept, pipe_accept, div_start;
    logic                 div_idle, div_done;
    logic [XLEN-1:0]      div_result;
    logic [ROB_IDX_W-1:0] div_rob_q;

    logic [XLEN-1:0]      alu_res, alu_ja;
    logic                 alu_je;
    logic [SHAMT_W-1:0]   sh_imm, sh_reg;
    logic [XLEN:0]        mul_a, mul_b;
    logic [2*XLEN-1:0]    prod;

    logic                 v_q   [MUL_STAGES];
    logic                 v_d   [MUL_STAGES];
    logic [XLEN-1:0]      res_q [MUL_STAGES];
    logic [XLEN-1:0]      res_d [MUL_STAGES];
    logic                 je_q  [MUL_STAGES];
    logic                 je_d  [MUL_STAGES];
    logic [XLEN-1:0]      ja_q  [MUL_STAGES];
    logic [XLEN-1:0]      ja_d  [MUL_STAGES];
    logic [ROB_IDX_W-1:0] rob_q [MUL_STAGES];
    logic [ROB_IDX_W-1:0] rob_d [MUL_STAGES];

    assign op              = instr_id_e'(instr_id_in);
    assign issue_ready_out = ~rst_in & rdy_in & div_idle;
    assign accept          = issue_valid_in & issue_ready_out & ~clear_in;
    assign pipe_accept     = accept & ~is_div_op(op);
    assign div_start       = accept & is_div_op(op);

    // Multiply operands widened by one bit so every RV32M variant is a
    // signed product; only the low 2*XLEN bits are ever needed.
    always_comb begin
        mul_a = {(op == ID_MULH || op == ID_MULHSU) & rs1_in[XLEN-1], rs1_in};
        mul_b = {(op == ID_MULH) & rs2_in[XLEN-1], rs2_in};
        prod  = (2*XLEN)'($signed(mul_a)) * (2*XLEN)'($signed(mul_b));
    end

    // Result, branch decision and target for every non-divide op.
    always_comb begin
        alu_res = '0;
        alu_je  = 1'b0;
        alu_ja  = '0;
        sh_imm  = imm_in[SHAMT_W-1:0];
        sh_reg  = rs2_in[SHAMT_W-1:0];
        case (op)
            ID_LUI:    alu_res = imm_in;
            ID_AUIPC:  alu_res = pc_in + imm_in;
            ID_JAL: begin
                alu_res = pc_in + XLEN'(4);
                alu_je  = 1'b1;
                alu_ja  = pc_in + imm_in;
            end
            ID_JALR: begin
                alu_res = pc_in + XLEN'(4);
                alu_je  = 1'b1;
                alu_ja  = (rs1_in + imm_in) & ~XLEN'(1);
            end
            ID_BEQ:  begin alu_je = (rs1_in == rs2_in);                   alu_ja = pc_in + imm_in; end
            ID_BNE:  begin alu_je = (rs1_in != rs2_in);                   alu_ja = pc_in + imm_in; end
            ID_BLT:  begin alu_je = ($signed(rs1_in) <  $signed(rs2_in)); alu_ja = pc_in + imm_in; end
            ID_BGE:  begin alu_je = ($signed(rs1_in) >= $signed(rs2_in)); alu_ja = pc_in + imm_in; end
            ID_BLTU: begin alu_je = (rs1_in <  rs2_in);                   alu_ja = pc_in + imm_in; end
            ID_BGEU: begin alu_je = (rs1_in >= rs2_in);                   alu_ja = pc_in + imm_in; end
            ID_ADDI:   alu_res = rs1_in + imm_in;
            ID_SLTI:   alu_res = XLEN'($signed(rs1_in) < $signed(imm_in));
            ID_SLTIU:  alu_res = XLEN'(rs1_in < imm_in);
            ID_XORI:   alu_res = rs1_in ^ imm_in;
            ID_ORI:    alu_res = rs1_in | imm_in;
            ID_ANDI:   alu_res = rs1_in & imm_in;
            ID_SLLI:   alu_res = rs1_in << sh_imm;
            ID_SRLI:   alu_res = rs1_in >> sh_imm;
            ID_SRAI:   alu_res = $unsigned($signed(rs1_in) >>> sh_imm);
            ID_ADD:    alu_res = rs1_in + rs2_in;
            ID_SUB:    alu_res = rs1_in - rs2_in;
            ID_SLL:    alu_res = rs1_in << sh_reg;
            ID_SLT:    alu_res = XLEN'($signed(rs1_in) < $signed(rs2_in));
            ID_SLTU:   alu_res = XLEN'(rs1_in < rs2_in);
            ID_XOR:    alu_res = rs1_in ^ rs2_in;
            ID_SRL:    alu_res = rs1_in >> sh_reg;
            ID_SRA:    alu_res = $unsigned($signed(rs1_in) >>> sh_reg);
            ID_OR:     alu_res = rs1_in | rs2_in;
            ID_AND:    alu_res = rs1_in & rs2_in;
            ID_MUL:    alu_res = prod[XLEN-1:0];
            ID_MULH, ID_MULHSU, ID_MULHU:
                       alu_res = prod[2*XLEN-1:XLEN];
            default: ;
        endcase
    end

    ex_md_unit_div_iter #(
        .XLEN (XLEN)
    ) u_div (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .start_i  (div_start),
        .signed_i (op == ID_DIV || op == ID_REM),
        .rem_i    (op == ID_REM || op == ID_REMU),
        .a_i      (rs1_in),
        .b_i      (rs2_in),
        .idle_c   (div_idle),
        .done_c   (div_done),
        .result_c (div_result)
    );

    // Result pipeline; bubbles carry an all-zero payload. The divider writes
    // the last stage directly, which is always empty by then.
    always_comb begin
        for (int i = 0; i < MUL_STAGES; i++) begin
            v_d[i]   = 1'b0;
            res_d[i] = '0;
            je_d[i]  = 1'b0;
            ja_d[i]  = '0;
            rob_d[i] = '0;
        end
        if (pipe_accept) begin
            v_d[0]   = 1'b1;
            res_d[0] = alu_res;
            je_d[0]  = alu_je;
            ja_d[0]  = alu_ja;
            rob_d[0] = rob_pos_in;
        end
        for (int i = 1; i < MUL_STAGES; i++) begin
            v_d[i]   = v_q[i-1];
            res_d[i] = res_q[i-1];
            je_d[i]  = je_q[i-1];
            ja_d[i]  = ja_q[i-1];
            rob_d[i] = rob_q[i-1];
        end
        if (div_done) begin
            v_d[MUL_STAGES-1]   = 1'b1;
            res_d[MUL_STAGES-1] = div_result;
            je_d[MUL_STAGES-1]  = 1'b0;
            ja_d[MUL_STAGES-1]  = '0;
            rob_d[MUL_STAGES-1] = div_rob_q;
        end
        if (clear_in) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                v_d[i]   = 1'b0;
                res_d[i] = '0;
                je_d[i]  = 1'b0;
                ja_d[i]  = '0;
                rob_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                v_q[i]   <= 1'b0;
                res_q[i] <= '0;
                je_q[i]  <= 1'b0;
                ja_q[i]  <= '0;
                rob_q[i] <= '0;
            end
            div_rob_q <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                v_q[i]   <= v_d[i];
                res_q[i] <= res_d[i];
                je_q[i]  <= je_d[i];
                ja_q[i]  <= ja_d[i];
                rob_q[i] <= rob_d[i];
            end
            if (div_start) begin
                div_rob_q <= rob_pos_in;
            end
        end
    end

    always_comb begin
        busy_out = ~div_idle;
        for (int i = 0; i < MUL_STAGES; i++) begin
            busy_out = busy_out | v_q[i];
        end
    end

    assign res_valid_out = v_q[MUL_STAGES-1];
    assign res_out       = res_q[MUL_STAGES-1];
    assign jump_en_out   = je_q[MUL_STAGES-1];
    assign jump_a_out    = ja_q[MUL_STAGES-1];
    assign rob_pos_out   = rob_q[MUL_STAGES-1];

endmodule

// File: tb/tb_ex_md_unit.sv
// tb_ex_md_unit: directed self-checking bench for ex_md_unit (XLEN=32, MUL_STAGES=2).
module tb_ex_md_unit;
    import ex_md_unit_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst, rdy, clr, iv;
    logic [INSTR_ID_W-1:0] iid;
    logic [31:0]           imm, rs1, rs2, pc;
    logic [ROB_IDX_W-1:0]  rob;
    logic                  ready, rv, je, busy;
    logic [31:0]           res, ja;
    logic [ROB_IDX_W-1:0]  robo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ex_md_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .rdy_in          (rdy),
        .clear_in        (clr),
        .issue_valid_in  (iv),
        .issue_ready_out (ready),
        .instr_id_in     (iid),
        .imm_in          (imm),
        .rs1_in          (rs1),
        .rs2_in          (rs2),
        .pc_in           (pc),
        .rob_pos_in      (rob),
        .res_valid_out   (rv),
        .res_out         (res),
        .jump_en_out     (je),
        .jump_a_out      (ja),
        .rob_pos_out     (robo),
        .busy_out        (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input instr_id_e id, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] im, input logic [31:0] p, input logic [3:0] r);
        iv = 1'b1; iid = id; rs1 = a; rs2 = b; imm = im; pc = p; rob = r;
    endtask

    task automatic no_issue;
        iv = 1'b0; iid = ID_NOP; rs1 = '0; rs2 = '0; imm = '0; pc = '0; rob = '0;
    endtask

    // Issue one pipelined op and return the outputs MUL_STAGES cycles later.
    task automatic run_pipe(input instr_id_e id, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] p,
                            output logic v, output logic [31:0] r, output logic j,
                            output logic [31:0] t);
        set_issue(id, a, b, im, p, 4'd9);
        tick;
        no_issue;
        tick;
        v = rv; r = res; j = je; t = ja;
    endtask

    // Issue one divide; ok stays 1 only if ready/valid stay low until the result.
    task automatic run_div(input instr_id_e id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] r, output logic v, output logic [31:0] q,
                           output logic [3:0] ro, output logic ok);
        set_issue(id, a, b, 32'd0, 32'd0, r);
        tick;
        no_issue;
        ok = 1'b1;
        for (int n = 1; n < 34; n++) begin
            if (ready !== 1'b0 || rv !== 1'b0) ok = 1'b0;
            tick;
        end
        v = rv; q = res; ro = robo;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        no_issue;
        tick; tick;
        total_cnt++; if ({ready, rv, je, busy} !== 4'b0) $display("FAIL reset_ctl got %b expected 0000", {ready, rv, je, busy}); else pass_cnt++;
        total_cnt++; if (res !== 32'd0 || ja !== 32'd0 || robo !== 4'd0) $display("FAIL reset_data got res=%h ja=%h rob=%h expected 0", res, ja, robo); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready_after got %b expected 1", ready); else pass_cnt++;
        tick;
    endtask

    task automatic test_addi;
        set_issue(ID_ADDI, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0, 4'd3);
        tick;
        no_issue;
        total_cnt++; if (rv !== 1'b0) $display("FAIL addi_early got %b expected 0", rv); else pass_cnt++;
        tick;
        total_cnt++; if (rv !== 1'b1 || res !== 32'hFFFF_FFFE || robo !== 4'd3 || je !== 1'b0)
            $display("FAIL addi got v=%b res=%h rob=%h je=%b expected 1 fffffffe 3 0", rv, res, robo, je); else pass_cnt++;
        tick;
        total_cnt++; if (rv !== 1'b0) $display("FAIL addi_one_shot got %b expected 0", rv); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] e [4];
        a[0] = 32'd1;   b[0] = 32'd2;   e[0] = 32'd3;
        a[1] = 32'd10;  b[1] = 32'd20;  e[1] = 32'd30;
        a[2] = 32'd100; b[2] = 32'd200; e[2] = 32'd300;
        a[3] = 32'hFFFF_FFFF; b[3] = 32'd1; e[3] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_issue(ID_ADD, a[i], b[i], 32'd0, 32'd0, 4'(i + 1));
            else no_issue;
            tick;
            if (i >= 1) begin
                total_cnt++;
                if (rv !== 1'b1 || res !== e[i-1] || robo !== 4'(i))
                    $display("FAIL b2b_%0d got v=%b res=%h rob=%h expected 1 %h %h", i - 1, rv, res, robo, e[i-1], 4'(i));
                else pass_cnt++;
            end
        end
        tick;
        total_cnt++; if (rv !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_drain got v=%b busy=%b expected 0 0", rv, busy); else pass_cnt++;
    endtask

    task automatic test_branch;
        logic v, j;
        logic [31:0] r, t;
        run_pipe(ID_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, v, r, j, t);
        total_cnt++; if (v !== 1'b1 || j !== 1'b1 || t !== 32'h120) $display("FAIL blt got v=%b je=%b ja=%h expected 1 1 120", v, j, t); else pass_cnt++;
        run_pipe(ID_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, v, r, j, t);
        total_cnt++; if (j !== 1'b0 || t !== 32'h120) $display("FAIL bltu got je=%b ja=%h expected 0 120", j, t); else pass_cnt++;
        run_pipe(ID_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, v, r, j, t);
        total_cnt++; if (j !== 1'b1 || t !== 32'h120) $display("FAIL bgeu got je=%b ja=%h expected 1 120", j, t); else pass_cnt++;
        run_pipe(ID_JALR, 32'h1001, 32'd0, 32'd6, 32'h200, v, r, j, t);
        total_cnt++; if (r !== 32'h204 || j !== 1'b1 || t !== 32'h1006) $display("FAIL jalr got res=%h je=%b ja=%h expected 204 1 1006", r, j, t); else pass_cnt++;
    endtask

    task automatic test_alu_mul;
        logic v, j;
        logic [31:0] r, t;
        run_pipe(ID_MULH, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, v, r, j, t);
        total_cnt++; if (r !== 32'h4000_0000) $display("FAIL mulh got %h expected 40000000", r); else pass_cnt++;
        run_pipe(ID_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, v, r, j, t);
        total_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu got %h expected ffffffff", r); else pass_cnt++;
        run_pipe(ID_MUL, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, v, r, j, t);
        total_cnt++; if (r !== 32'hFFFF_FFEB || j !== 1'b0) $display("FAIL mul got %h je=%b expected ffffffeb 0", r, j); else pass_cnt++;
        run_pipe(ID_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, v, r, j, t);
        total_cnt++; if (r !== 32'hFFFF_FFFE) $display("FAIL mulhu got %h expected fffffffe", r); else pass_cnt++;
        run_pipe(ID_SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'd0, v, r, j, t);
        total_cnt++; if (r !== 32'hF800_0000) $display("FAIL srai got %h expected f8000000", r); else pass_cnt++;
        run_pipe(ID_SLL, 32'd1, 32'h21, 32'd0, 32'd0, v, r, j, t);
        total_cnt++; if (r !== 32'd2) $display("FAIL sll_shamt got %h expected 2", r); else pass_cnt++;
        run_pipe(ID_SLTI, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, v, r, j, t);
        total_cnt++; if (r !== 32'd1) $display("FAIL slti got %h expected 1", r); else pass_cnt++;
    endtask

    task automatic test_div;
        logic v, ok;
        logic [31:0] q;
        logic [3:0] ro;
        run_div(ID_DIV, 32'hFFFF_FFF9, 32'd2, 4'd6, v, q, ro, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL div_timing got early ready/valid expected none"); else pass_cnt++;
        total_cnt++; if (v !== 1'b1 || q !== 32'hFFFF_FFFD || ro !== 4'd6) $display("FAIL div got v=%b q=%h rob=%h expected 1 fffffffd 6", v, q, ro); else pass_cnt++;
        total_cnt++; if (ready !== 1'b1) $display("FAIL div_ready_after got %b expected 1", ready); else pass_cnt++;
        tick;
        total_cnt++; if (rv !== 1'b0 || busy !== 1'b0) $display("FAIL div_one_shot got v=%b busy=%b expected 0 0", rv, busy); else pass_cnt++;
        run_div(ID_REM, 32'hFFFF_FFF9, 32'd2, 4'd7, v, q, ro, ok);
        total_cnt++; if (v !== 1'b1 || q !== 32'hFFFF_FFFF) $display("FAIL rem got v=%b q=%h expected 1 ffffffff", v, q); else pass_cnt++;
        run_div(ID_DIVU, 32'd5, 32'd0, 4'd1, v, q, ro, ok);
        total_cnt++; if (v !== 1'b1 || q !== 32'hFFFF_FFFF || ok !== 1'b1) $display("FAIL divu_zero got v=%b q=%h ok=%b expected 1 ffffffff 1", v, q, ok); else pass_cnt++;
        run_div(ID_REMU, 32'd5, 32'd0, 4'd1, v, q, ro, ok);
        total_cnt++; if (q !== 32'd5) $display("FAIL remu_zero got %h expected 5", q); else pass_cnt++;
        run_div(ID_DIV, 32'hFFFF_FFFB, 32'd0, 4'd1, v, q, ro, ok);
        total_cnt++; if (q !== 32'hFFFF_FFFF) $display("FAIL div_zero got %h expected ffffffff", q); else pass_cnt++;
        run_div(ID_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd2, v, q, ro, ok);
        total_cnt++; if (v !== 1'b1 || q !== 32'd0) $display("FAIL rem_ovf got v=%b q=%h expected 1 0", v, q); else pass_cnt++;
        run_div(ID_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd2, v, q, ro, ok);
        total_cnt++; if (q !== 32'h8000_0000) $display("FAIL div_ovf got %h expected 80000000", q); else pass_cnt++;
        tick;
    endtask

    task automatic test_clear;
        logic seen;
        set_issue(ID_DIV, 32'd100, 32'd3, 32'd0, 32'd0, 4'd4);
        tick;
        no_issue;
        for (int n = 0; n < 10; n++) tick;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        #1;
        total_cnt++; if (rv !== 1'b0 || busy !== 1'b0 || ready !== 1'b1)
            $display("FAIL clear_div got v=%b busy=%b ready=%b expected 0 0 1", rv, busy, ready); else pass_cnt++;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin tick; if (rv !== 1'b0) seen = 1'b1; end
        total_cnt++; if (seen !== 1'b0) $display("FAIL clear_div_quiet got late valid expected none"); else pass_cnt++;

        set_issue(ID_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
        tick;
        set_issue(ID_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 4'd2);
        tick;
        set_issue(ID_ADD, 32'd3, 32'd3, 32'd0, 32'd0, 4'd3);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        no_issue;
        #1;
        total_cnt++; if (rv !== 1'b0 || busy !== 1'b0 || ready !== 1'b1)
            $display("FAIL clear_pipe got v=%b busy=%b ready=%b expected 0 0 1", rv, busy, ready); else pass_cnt++;
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin tick; if (rv !== 1'b0) seen = 1'b1; end
        total_cnt++; if (seen !== 1'b0) $display("FAIL clear_pipe_quiet got late valid expected none"); else pass_cnt++;
    endtask

    task automatic test_stall;
        logic bad;
        set_issue(ID_ADD, 32'h11, 32'h22, 32'd0, 32'd0, 4'd5);
        tick;
        no_issue;
        rdy = 1'b1;
        rdy = 1'b0;
        bad = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick;
            if (rv !== 1'b0 || ready !== 1'b0) bad = 1'b1;
        end
        total_cnt++; if (bad !== 1'b0) $display("FAIL stall_frozen got valid/ready during stall expected 0"); else pass_cnt++;
        rdy = 1'b1;
        tick;
        total_cnt++; if (rv !== 1'b1 || res !== 32'h33 || robo !== 4'd5)
            $display("FAIL stall_late got v=%b res=%h rob=%h expected 1 33 5", rv, res, robo); else pass_cnt++;
        rdy = 1'b0;
        tick; tick;
        total_cnt++; if (rv !== 1'b1 || res !== 32'h33) $display("FAIL stall_hold got v=%b res=%h expected 1 33", rv, res); else pass_cnt++;
        rdy = 1'b1;
        tick;
        total_cnt++; if (rv !== 1'b0) $display("FAIL stall_release got %b expected 0", rv); else pass_cnt++;
    endtask

    task automatic test_reset_mid_div;
        set_issue(ID_ADD, 32'd5, 32'd6, 32'd0, 32'd0, 4'd7);
        tick;
        set_issue(ID_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 4'd8);
        tick;
        no_issue;
        total_cnt++; if (rv !== 1'b1 || res !== 32'd11 || robo !== 4'd7) $display("FAIL pre_rst got v=%b res=%h rob=%h expected 1 b 7", rv, res, robo); else pass_cnt++;
        for (int n = 0; n < 5; n++) tick;
        total_cnt++; if (busy !== 1'b1 || ready !== 1'b0) $display("FAIL mid_div got busy=%b ready=%b expected 1 0", busy, ready); else pass_cnt++;
        rst = 1'b1;
        tick;
        total_cnt++; if ({ready, rv, je, busy} !== 4'b0 || res !== 32'd0 || ja !== 32'd0 || robo !== 4'd0)
            $display("FAIL rst_mid_div got ctl=%b res=%h ja=%h rob=%h expected 0", {ready, rv, je, busy}, res, ja, robo); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (ready !== 1'b1) $display("FAIL rst_mid_div_ready got %b expected 1", ready); else pass_cnt++;
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within budget");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_addi;
        test_back_to_back;
        test_branch;
        test_alu_mul;
        test_div;
        test_clear;
        test_stall;
        test_reset_mid_div;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
